// File: rtl/drop_scheduler_pkg.sv
// Shared types and codes for the drop scheduler and anything that talks to it.
package drop_scheduler_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COUNT  = 3'd2,
    S_FIRE   = 3'd3,
    S_REJECT = 3'd4
  } state_e;

  // Externally visible status codes.
  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_CNT = 2'b01,
    ST_REJ = 2'b10,
    ST_ABT = 2'b11
  } status_e;

  // Fall time is half of sqrt(h) in 8.8 fixed point, truncated.
  function automatic logic [15:0] fall_time(input logic [15:0] sqrt_h);
    return sqrt_h >> 1;
  endfunction

endpackage

// File: rtl/drop_scheduler_tick_gen.sv
// Countdown prescaler: emits a registered one-cycle tick every TICK_DIV
// cycles after clr is released; the first tick lands TICK_DIV cycles
// after the last cleared cycle.
module tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick_q;

  // Divider counter with a registered terminal-count tick; clr holds it at zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation order cannot change the result.
    if (rst || clr) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (div_q == LAST);
      div_q  <= (div_q == LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/drop_scheduler.sv
// Drop scheduler: latches a fall time derived from sqrt(h), rejects it if it
// is below the minimum, otherwise counts it down in prescaled ticks and emits
// a one-cycle drop pulse. Abort cancels a pending countdown.
module drop_scheduler
  import drop_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] sqrt_in,
  input  logic [CNT_W-1:0] t_lim,
  input  logic             abort,
  output logic [CNT_W-1:0] t_fall,
  output logic             busy,
  output logic             drop,
  output logic [1:0]       status
);

  state_e           state_q;
  status_e          status_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] t_fall_q;
  logic [CNT_W-1:0] t_lim_q;
  logic             busy_q;
  logic             drop_q;

  logic             tick;
  logic             prescale_clr;

  // The prescaler only runs while counting, so it restarts from zero on
  // every COUNT entry.
  assign prescale_clr = (state_q != S_COUNT);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (prescale_clr),
    .tick (tick)
  );

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      cnt_q    <= '0;
      t_fall_q <= '0;
      t_lim_q  <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            t_fall_q <= CNT_W'(fall_time(16'(sqrt_in)));
            t_lim_q  <= t_lim;
            busy_q   <= 1'b1;
            status_q <= ST_CNT;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            busy_q   <= 1'b0;
            status_q <= ST_ABT;
            state_q  <= S_IDLE;
          end else if (t_fall_q < t_lim_q) begin
            busy_q   <= 1'b0;
            status_q <= ST_REJ;
            state_q  <= S_REJECT;
          end else begin
            cnt_q   <= t_fall_q;
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          // Abort outranks both the terminal count and a pending tick.
          if (abort) begin
            busy_q   <= 1'b0;
            status_q <= ST_ABT;
            state_q  <= S_IDLE;
          end else if (cnt_q == '0) begin
            drop_q   <= 1'b1;
            status_q <= ST_OK;
            state_q  <= S_FIRE;
          end else if (tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_FIRE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_REJECT: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign t_fall = t_fall_q;
  assign busy   = busy_q;
  assign drop   = drop_q;
  assign status = status_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// Bench for drop_scheduler: one instance with TICK_DIV=1 and one with
// TICK_DIV=3, directed scenarios plus randomized runs against a timing
// model derived from the fall-time formula.
module tb_drop_scheduler;
  import drop_scheduler_pkg::*;

  localparam int TD0 = 1;
  localparam int TD1 = 3;

  logic        clk;
  logic        rst;
  logic        start_s  [2];
  logic [15:0] sqrt_s   [2];
  logic [15:0] tlim_s   [2];
  logic        abort_s  [2];
  logic [15:0] tfall_o  [2];
  logic        busy_o   [2];
  logic        drop_o   [2];
  logic [1:0]  status_o [2];

  int checks   = 0;
  int failures = 0;

  drop_scheduler #(.TICK_DIV(TD0), .CNT_W(16)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .start   (start_s[0]),
    .sqrt_in (sqrt_s[0]),
    .t_lim   (tlim_s[0]),
    .abort   (abort_s[0]),
    .t_fall  (tfall_o[0]),
    .busy    (busy_o[0]),
    .drop    (drop_o[0]),
    .status  (status_o[0])
  );

  drop_scheduler #(.TICK_DIV(TD1), .CNT_W(16)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start_s[1]),
    .sqrt_in (sqrt_s[1]),
    .t_lim   (tlim_s[1]),
    .abort   (abort_s[1]),
    .t_fall  (tfall_o[1]),
    .busy    (busy_o[1]),
    .drop    (drop_o[1]),
    .status  (status_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int td(input int idx);
    return (idx == 0) ? TD0 : TD1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and follow it to completion, checking against the model:
  // t_fall = sqrt/2; reject if t_fall < t_lim; else drop at 1 cycle after
  // COUNT entry for t_fall=0, or TICK_DIV*t_fall+2 cycles otherwise.
  task automatic run_drop(input int idx, input logic [15:0] sq, input logic [15:0] tl);
    int tf, exp_off, drops, first, busy_low;
    tf = int'(sq) / 2;
    start_s[idx] = 1'b1;
    sqrt_s[idx]  = sq;
    tlim_s[idx]  = tl;
    step();
    start_s[idx] = 1'b0;
    check("load_busy", busy_o[idx], 1);
    check("load_tfall", tfall_o[idx], tf);
    check("load_status", status_o[idx], ST_CNT);
    if (tf < int'(tl)) begin
      step();
      check("rej_busy", busy_o[idx], 0);
      check("rej_status", status_o[idx], ST_REJ);
      check("rej_drop", drop_o[idx], 0);
      step();
      check("rej_idle_status", status_o[idx], ST_REJ);
      check("rej_idle_drop", drop_o[idx], 0);
    end else begin
      exp_off = (tf == 0) ? 1 : td(idx) * tf + 2;
      step();
      check("count_status", status_o[idx], ST_CNT);
      drops = 0;
      first = -1;
      busy_low = 0;
      if (drop_o[idx]) begin
        drops++;
        first = 0;
      end
      for (int k = 1; k <= exp_off; k++) begin
        step();
        if (drop_o[idx]) begin
          drops++;
          if (first < 0) first = k;
        end
        if (!busy_o[idx]) busy_low = 1;
      end
      check("drop_time", first, exp_off);
      check("drop_count", drops, 1);
      check("busy_held", busy_low, 0);
      step();
      check("done_busy", busy_o[idx], 0);
      check("done_drop", drop_o[idx], 0);
      check("done_status", status_o[idx], ST_OK);
    end
  endtask

  initial begin
    int drops, busy_seen, first, second, win, exp_off;
    logic [15:0] rs, rl;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      sqrt_s[i]  = '0;
      tlim_s[i]  = '0;
      abort_s[i] = 1'b0;
    end
    step(); step(); step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_tfall", tfall_o[i], 0);
      check("rst_busy", busy_o[i], 0);
      check("rst_drop", drop_o[i], 0);
      check("rst_status", status_o[i], ST_OK);
    end

    // Long countdown with TICK_DIV=1: drop 514 cycles after COUNT entry.
    run_drop(0, 16'h0400, 16'h0000);
    // Rejection: 0x200 < 0x300.
    run_drop(0, 16'h0400, 16'h0300);
    // Zero fall time, then equality boundary accepted.
    run_drop(0, 16'h0001, 16'h0000);
    run_drop(0, 16'h0100, 16'h0080);
    // Prescaled countdown: T=3, TICK_DIV=3 -> 11 cycles.
    run_drop(1, 16'h0006, 16'h0000);

    // Abort 10 cycles into COUNT, with a start and new sqrt ignored mid-run.
    start_s[0] = 1'b1; sqrt_s[0] = 16'h0400; tlim_s[0] = 16'h0000;
    step();
    start_s[0] = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    start_s[0] = 1'b1; sqrt_s[0] = 16'h0002;
    step();
    start_s[0] = 1'b0; sqrt_s[0] = 16'h0400;
    check("tfall_hold", tfall_o[0], 16'h0200);
    check("busy_start_ignored", status_o[0], ST_CNT);
    for (int i = 0; i < 4; i++) step();
    abort_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    check("abort_busy", busy_o[0], 0);
    check("abort_status", status_o[0], ST_ABT);
    check("abort_drop", drop_o[0], 0);
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (drop_o[0]) drops++;
    end
    check("abort_no_drop", drops, 0);
    check("abort_status_hold", status_o[0], ST_ABT);
    run_drop(0, 16'h0020, 16'h0000);

    // Abort in IDLE is ignored.
    abort_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    check("idle_abort_status", status_o[0], ST_OK);

    // Abort in LOAD.
    start_s[0] = 1'b1; sqrt_s[0] = 16'h0040;
    step();
    start_s[0] = 1'b0;
    abort_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    check("load_abort_status", status_o[0], ST_ABT);
    check("load_abort_busy", busy_o[0], 0);

    // Abort in FIRE is ignored.
    start_s[0] = 1'b1; sqrt_s[0] = 16'h0001;
    step();
    start_s[0] = 1'b0;
    step();
    step();
    check("fire_drop", drop_o[0], 1);
    abort_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    check("fire_abort_status", status_o[0], ST_OK);
    check("fire_abort_busy", busy_o[0], 0);

    // Start held high: one drop per pass, period = countdown + 3.
    exp_off = TD0 * 8 + 2;
    start_s[0] = 1'b1; sqrt_s[0] = 16'h0010; tlim_s[0] = 16'h0000;
    drops = 0; first = -1; second = -1;
    win = 3 * (exp_off + 3);
    for (int k = 1; k <= win; k++) begin
      step();
      if (drop_o[0]) begin
        drops++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    start_s[0] = 1'b0;
    check("hold_drops", drops, 3);
    check("hold_first", first, exp_off + 2);
    check("hold_period", second - first, exp_off + 3);
    for (int i = 0; i < exp_off + 4; i++) step();
    check("hold_idle_busy", busy_o[0], 0);

    // Reset mid-COUNT together with start.
    start_s[0] = 1'b1; sqrt_s[0] = 16'h0400;
    step();
    start_s[0] = 1'b0;
    for (int i = 0; i < 50; i++) step();
    rst = 1'b1; start_s[0] = 1'b1;
    step();
    rst = 1'b0; start_s[0] = 1'b0;
    check("mrst_tfall", tfall_o[0], 0);
    check("mrst_busy", busy_o[0], 0);
    check("mrst_drop", drop_o[0], 0);
    check("mrst_status", status_o[0], ST_OK);
    drops = 0; busy_seen = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (drop_o[0]) drops++;
      if (busy_o[0]) busy_seen++;
    end
    check("mrst_no_drop", drops, 0);
    check("mrst_no_busy", busy_seen, 0);

    // Randomized runs on both prescaler settings.
    for (int idx = 0; idx < 2; idx++) begin
      for (int n = 0; n < 12; n++) begin
        rs = 16'($urandom_range(0, 255));
        rl = 16'($urandom_range(0, 140));
        run_drop(idx, rs, rl);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
